// File: rtl/bo_soma_regressiva.sv
// Datapath for the countdown summation (soma regressiva).
// A down-counter is loaded with N and decremented by the control block while
// an accumulator adds each counter value. This gives result = N + (N-1) + ... + 1.
// When the control block reports completion, the finished sum is published.
module bo_soma_regressiva #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     n_in,
    input  logic                 set,
    input  logic                 rac,
    input  logic                 cac,
    input  logic                 dec,
    input  logic                 pronto,
    output logic                 zero,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 result_valid,
    output logic                 err
);

    logic [WIDTH-1:0]     cnt;
    logic [ACC_WIDTH-1:0] acc;
    logic                 busy;
    logic [ACC_WIDTH-1:0] cnt_ext;

    assign cnt_ext = {{(ACC_WIDTH-WIDTH){1'b0}}, cnt};

    // Status for the control block comes straight from the registered count.
    assign zero = (cnt == '0);

    // Down-counter: load wins over decrement, and the count saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (set) begin
            cnt <= n_in;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Accumulator: clear wins over accumulate, and the pre-edge count is added.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (rac) begin
            acc <= '0;
        end else if (cac) begin
            acc <= acc + cnt_ext;
        end
    end

    // Run tracking: any accumulate marks a live run, and completion ends it.
    // If both happen in the same cycle, completion wins so no run stays open.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
        end else if (pronto) begin
            busy <= 1'b0;
        end else if (cac) begin
            busy <= 1'b1;
        end
    end

    // Publish the sum only for runs that actually accumulated something.
    always_ff @(posedge clk) begin
        if (rst) begin
            result       <= '0;
            result_valid <= 1'b0;
        end else if (pronto && busy) begin
            result       <= acc;
            result_valid <= 1'b1;
        end else begin
            result_valid <= 1'b0;
        end
    end

    // Sticky protocol error: decrementing past zero or loading while accumulating.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((dec && !set && (cnt == '0)) || (set && cac)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bo_soma_regressiva.sv
// Scoreboard bench for bo_soma_regressiva: each completed run pushes its
// arithmetic sum N*(N+1)/2, and a monitor pops it on every result_valid pulse.
module tb_bo_soma_regressiva;

    localparam int WIDTH     = 8;
    localparam int ACC_WIDTH = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [WIDTH-1:0]     n_in;
    logic                 set, rac, cac, dec, pronto;
    logic                 zero;
    logic [ACC_WIDTH-1:0] result;
    logic                 result_valid;
    logic                 err;

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];
    int last_result = 0;

    bo_soma_regressiva #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
        .clk(clk), .rst(rst), .n_in(n_in), .set(set), .rac(rac), .cac(cac),
        .dec(dec), .pronto(pronto), .zero(zero), .result(result),
        .result_valid(result_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Monitor: every published result must match the oldest outstanding sum.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result_valid: got result %0d, want no pulse", result);
            end else begin
                chk("result_on_valid", int'(result), exp_q.pop_front());
            end
        end
    end

    // Apply one cycle of commands; returns 1 time unit after the sampling edge.
    task automatic drive(input logic s, input logic r, input logic c,
                         input logic d, input logic p, input logic [WIDTH-1:0] n);
        set = s; rac = r; cac = c; dec = d; pronto = p; n_in = n;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(0, 0, 0, 0, 0, WIDTH'($urandom));
    endtask

    // A complete run as the control block would sequence it.
    task automatic run(input int n);
        int expected;
        drive(1, 1, 0, 0, 0, WIDTH'(n));
        chk("zero_after_load", int'(zero), (n == 0) ? 1 : 0);
        for (int k = 1; k <= n; k++) begin
            drive(0, 0, 1, 1, 0, WIDTH'($urandom));
            chk("zero_during_run", int'(zero), (k == n) ? 1 : 0);
        end
        expected = (n * (n + 1) / 2) % (1 << ACC_WIDTH);
        if (n > 0) begin
            exp_q.push_back(expected);
            last_result = expected;
        end
        drive(0, 0, 0, 0, 1, WIDTH'($urandom));
        idle(1);
        chk("result_after_run", int'(result), last_result);
        chk("err_after_run", int'(err), 0);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, '0);
        drive(1, 1, 1, 1, 1, 8'hff);
        chk("reset_zero", int'(zero), 1);
        chk("reset_result", int'(result), 0);
        chk("reset_valid", int'(result_valid), 0);
        chk("reset_err", int'(err), 0);
        rst = 1'b0;
        idle(2);

        run(5);
        chk("sum5", int'(result), 15);
        run(0);
        chk("n0_keeps_result", int'(result), 15);
        run(255);
        chk("sum255", int'(result), 32640);
        chk("sum255_zero", int'(zero), 1);

        // Reset in the middle of a run discards the partial sum.
        drive(1, 1, 0, 0, 0, 8'd10);
        for (int k = 0; k < 3; k++) drive(0, 0, 1, 1, 0, 8'd10);
        rst = 1'b1;
        drive(0, 0, 1, 1, 1, 8'd10);
        rst = 1'b0;
        chk("midrun_rst_zero", int'(zero), 1);
        chk("midrun_rst_result", int'(result), 0);
        chk("midrun_rst_valid", int'(result_valid), 0);
        chk("midrun_rst_err", int'(err), 0);
        last_result = 0;
        idle(1);
        run(3);
        chk("sum3", int'(result), 6);

        // Randomized runs with random idle gaps and n_in noise.
        for (int r = 0; r < 25; r++) begin
            run(int'($urandom_range(0, 40)));
            idle(int'($urandom_range(0, 3)));
        end

        // Load wins over decrement: count must be 7, so zero arrives after 7 decs.
        drive(1, 0, 0, 1, 0, 8'd7);
        chk("set_over_dec_zero", int'(zero), 0);
        for (int k = 1; k <= 7; k++) begin
            drive(0, 0, 0, 1, 0, 8'd0);
            chk("dec_only_zero", int'(zero), (k == 7) ? 1 : 0);
        end
        chk("set_over_dec_err", int'(err), 0);

        // Clear wins over accumulate: published sum must be 0.
        drive(1, 1, 0, 0, 0, 8'd2);
        drive(0, 0, 1, 1, 0, 8'd0);
        drive(0, 1, 1, 0, 0, 8'd0);
        chk("rac_cac_zero", int'(zero), 0);
        exp_q.push_back(0);
        drive(0, 0, 0, 0, 1, 8'd0);
        idle(1);
        chk("rac_over_cac_result", int'(result), 0);

        // Decrement at zero: no wrap, sticky error.
        drive(0, 0, 0, 1, 0, 8'd0);
        drive(0, 0, 0, 1, 0, 8'd0);
        chk("dec_at_zero_zero", int'(zero), 1);
        chk("dec_at_zero_err", int'(err), 1);
        idle(3);
        chk("err_sticky", int'(err), 1);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 8'd0);
        rst = 1'b0;
        chk("err_cleared_by_rst", int'(err), 0);

        // Load and accumulate together is an illegal command mix.
        drive(1, 0, 1, 0, 0, 8'd9);
        chk("set_cac_err", int'(err), 1);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 8'd0);
        rst = 1'b0;
        idle(3);

        chk("pending_results", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
